// File: rtl/axi_lite_sram_resp_if.sv
// AXI4-Lite bus bundle between a master and the SRAM responder.
// The slave modport is the responder's view. The master modport is the view
// of whatever drives requests.
interface axi_lite_sram_resp_if #(
  parameter int ADDR_WIDTH = 32
);
  // read address / read data
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  // write address / write data / write response
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport slave (
    input  araddr, arvalid, rready,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arvalid, rready,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_sram_resp.sv
// AXI4-Lite slave in front of a 32-bit word SRAM.
// The read and write engines are independent FSMs, and each has a fixed latency.
// - rvalid rises RD_LAT cycles after the AR handshake cycle.
// - bvalid rises WR_LAT cycles after the later of the AW/W handshake cycles.
// All ready/valid outputs are registered, so no ready depends combinationally on a valid.
module axi_lite_sram_resp #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 12,
  parameter int RD_LAT     = 2,
  parameter int WR_LAT     = 1
) (
  input  logic                clk,
  input  logic                rst,
  axi_lite_sram_resp_if.slave bus
);
  localparam int         WORDS     = 1 << DEPTH_LOG2;
  localparam logic [3:0] RD_LOAD   = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_LOAD   = 4'(WR_LAT - 1);
  localparam bit         RD_DIRECT = (RD_LAT == 1);
  localparam bit         WR_DIRECT = (WR_LAT == 1);
  localparam logic [1:0] OKAY      = 2'b00;
  localparam logic [1:0] SLVERR    = 2'b10;

  typedef logic [DEPTH_LOG2-1:0] idx_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;

  // Storage. It is deliberately not reset.
  logic [31:0] mem_q [WORDS];

  // Address decode. Byte-lane bits [1:0] carry no meaning for a word SRAM.
  idx_t ar_idx, aw_idx;
  logic ar_oor, aw_oor;
  logic unused_addr_lsbs;
  assign ar_idx = bus.araddr[DEPTH_LOG2+1:2];
  assign aw_idx = bus.awaddr[DEPTH_LOG2+1:2];
  assign ar_oor = (bus.araddr >> (DEPTH_LOG2 + 2)) != '0;
  assign aw_oor = (bus.awaddr >> (DEPTH_LOG2 + 2)) != '0;
  assign unused_addr_lsbs = ^{bus.araddr[1:0], bus.awaddr[1:0]};

  // ---------------------------------------------------------------- read
  rstate_t     rstate_q;
  logic [3:0]  rcnt_q;
  idx_t        ridx_q;
  logic        roor_q;
  logic        arready_q, rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  idx_t        rd_idx;
  logic        rd_oor, rd_fire;
  logic [31:0] rd_word;

  // Select which address to sample and decide when to sample.
  // With a one-cycle latency, the address comes straight from the AR channel.
  // Otherwise, sampling happens on the decrement that takes the counter to zero.
  always_comb begin
    rd_idx  = (rstate_q == R_IDLE) ? ar_idx : ridx_q;
    rd_oor  = (rstate_q == R_IDLE) ? ar_oor : roor_q;
    rd_word = rd_oor ? 32'h0 : mem_q[rd_idx];
    rd_fire = ((rstate_q == R_IDLE) && bus.arvalid && arready_q && RD_DIRECT) ||
              ((rstate_q == R_WAIT) && (rcnt_q == 4'd1));
  end

  // Read FSM: accept AR, count down the latency, then hold the response until rready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q  <= R_IDLE;
      rcnt_q    <= '0;
      ridx_q    <= '0;
      roor_q    <= 1'b0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (bus.arvalid && arready_q) begin
            ridx_q    <= ar_idx;
            roor_q    <= ar_oor;
            rcnt_q    <= RD_LOAD;
            arready_q <= 1'b0;
            rstate_q  <= R_WAIT;
          end
        end
        R_WAIT: begin
          rcnt_q <= rcnt_q - 4'd1;
        end
        R_RESP: begin
          if (bus.rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
      // The sample overrides the state chosen above.
      // It reads memory before this edge's write commit, so a collision returns old data.
      if (rd_fire) begin
        rdata_q  <= rd_word;
        rresp_q  <= rd_oor ? SLVERR : OKAY;
        rvalid_q <= 1'b1;
        rstate_q <= R_RESP;
      end
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;

  // --------------------------------------------------------------- write
  wstate_t     wstate_q;
  logic [3:0]  wcnt_q;
  idx_t        widx_q;
  logic        woor_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_got_q, w_got_q;
  logic        awready_q, wready_q, bvalid_q;
  logic [1:0]  bresp_q;

  logic        aw_hs, w_hs, both_have, wr_fire;
  idx_t        eff_idx;
  logic        eff_oor;
  logic [31:0] eff_data;
  logic [3:0]  eff_strb;

  // Merge the captured halves with whatever is handshaking this cycle.
  // This lets a single-cycle-latency write commit on the edge that completes it.
  always_comb begin
    aw_hs     = bus.awvalid && awready_q;
    w_hs      = bus.wvalid && wready_q;
    both_have = (aw_got_q || aw_hs) && (w_got_q || w_hs);
    eff_idx   = aw_got_q ? widx_q  : aw_idx;
    eff_oor   = aw_got_q ? woor_q  : aw_oor;
    eff_data  = w_got_q  ? wdata_q : bus.wdata;
    eff_strb  = w_got_q  ? wstrb_q : bus.wstrb;
    wr_fire   = ((wstate_q == W_IDLE) && both_have && WR_DIRECT) ||
                ((wstate_q == W_WAIT) && (wcnt_q == 4'd1));
  end

  // Write FSM: collect AW and W in any order, count down the latency, then hold B until bready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      wcnt_q    <= '0;
      widx_q    <= '0;
      woor_q    <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (aw_hs) begin
            widx_q    <= aw_idx;
            woor_q    <= aw_oor;
            aw_got_q  <= 1'b1;
            awready_q <= 1'b0;
          end
          if (w_hs) begin
            wdata_q  <= bus.wdata;
            wstrb_q  <= bus.wstrb;
            w_got_q  <= 1'b1;
            wready_q <= 1'b0;
          end
          if (both_have) begin
            wcnt_q   <= WR_LOAD;
            wstate_q <= W_WAIT;
          end
        end
        W_WAIT: begin
          wcnt_q <= wcnt_q - 4'd1;
        end
        W_RESP: begin
          if (bus.bready) begin
            bvalid_q  <= 1'b0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= eff_oor ? SLVERR : OKAY;
        wstate_q <= W_RESP;
      end
    end
  end

  // Commit the write in the same edge where bvalid rises.
  // Only the strobed bytes of an in-range word are written.
  // rst gating keeps an edge taken during reset from committing anything.
  always_ff @(posedge clk) begin
    if (wr_fire && !eff_oor && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (eff_strb[b]) mem_q[eff_idx][8*b +: 8] <= eff_data[8*b +: 8];
      end
    end
  end

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
endmodule

// File: tb/tb_axi_lite_sram_resp.sv
// Bench for axi_lite_sram_resp.
// Directed scenarios run first, followed by concurrent randomized reads and writes.
// A transaction-level model predicts the ready, valid and response outputs.
// Every cycle, those predictions are compared against the DUT.
module tb_axi_lite_sram_resp;
  localparam int AW  = 16;
  localparam int DL  = 6;
  localparam int NW  = 1 << DL;
  localparam int RDL = 3;
  localparam int WRL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_sram_resp_if #(.ADDR_WIDTH(AW)) ifc();

  axi_lite_sram_resp #(
    .ADDR_WIDTH(AW), .DEPTH_LOG2(DL), .RD_LAT(RDL), .WR_LAT(WRL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Each transaction is tracked as a count of clock edges.
  // - A read samples memory on its RD_LAT-th edge, counting the handshake edge as the first.
  // - A write commits on its WR_LAT-th edge, counting the edge that completes both halves.
  // Reads are evaluated before writes on each edge, so a read that collides with a write sees the old data.
  logic [31:0]   mm [NW];
  bit            rb, rv, awg, wg, wp, bv;
  int            rleft, wleft;
  logic [AW-1:0] ra, wa;
  logic [31:0]   wdm, erd;
  logic [3:0]    wsm;
  logic [1:0]    err, ebr;

  function automatic bit oor(input logic [AW-1:0] a);
    return int'(a) >= 4 * NW;
  endfunction

  function automatic int widx(input logic [AW-1:0] a);
    return (int'(a) / 4) % NW;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      rb = 0; rv = 0; awg = 0; wg = 0; wp = 0; bv = 0;
    end else begin
      if (rv) begin
        if (ifc.rready) begin rv = 0; rb = 0; end
      end else if (rb) rleft--;
      else if (ifc.arvalid) begin rb = 1; ra = ifc.araddr; rleft = RDL - 1; end
      if (rb && !rv && rleft == 0) begin
        rv  = 1;
        err = oor(ra) ? 2'b10 : 2'b00;
        erd = oor(ra) ? 32'h0 : mm[widx(ra)];
      end
      if (bv) begin
        if (ifc.bready) begin bv = 0; awg = 0; wg = 0; wp = 0; end
      end else if (wp) wleft--;
      else begin
        if (!awg && ifc.awvalid) begin awg = 1; wa = ifc.awaddr; end
        if (!wg && ifc.wvalid) begin wg = 1; wdm = ifc.wdata; wsm = ifc.wstrb; end
        if (awg && wg) begin wp = 1; wleft = WRL - 1; end
      end
      if (wp && !bv && wleft == 0) begin
        bv  = 1;
        ebr = oor(wa) ? 2'b10 : 2'b00;
        if (!oor(wa))
          for (int b = 0; b < 4; b++)
            if (wsm[b]) mm[widx(wa)][8*b +: 8] = wdm[8*b +: 8];
      end
    end
  end

  // Per-cycle compare of DUT outputs against the model, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("arready", 32'(ifc.arready), 32'(!rb));
      chk("rvalid",  32'(ifc.rvalid),  32'(rv));
      if (rv) begin
        chk("rdata", ifc.rdata, erd);
        chk("rresp", 32'(ifc.rresp), 32'(err));
      end
      chk("awready", 32'(ifc.awready), 32'(!awg));
      chk("wready",  32'(ifc.wready),  32'(!wg));
      chk("bvalid",  32'(ifc.bvalid),  32'(bv));
      if (bv) chk("bresp", 32'(ifc.bresp), 32'(ebr));
    end
  end

  // ---------------------------------------------------------------- drivers
  // Every task starts and ends just after a falling edge.
  task automatic rd(input logic [AW-1:0] a, input int hold,
                    output logic [31:0] d, output logic [1:0] r, output int lat);
    int n, k;
    ifc.araddr = a; ifc.arvalid = 1'b1;
    n = 0;
    while (!ifc.arready && n < 100) begin @(negedge clk); n++; end
    chk("ar_wait", 32'(n < 100), 32'd1);
    k = cyc + 1;
    @(negedge clk); ifc.arvalid = 1'b0;
    n = 0;
    while (!ifc.rvalid && n < 100) begin @(negedge clk); n++; end
    chk("r_wait", 32'(n < 100), 32'd1);
    lat = cyc - k + 1;
    d = ifc.rdata; r = ifc.rresp;
    repeat (hold) @(negedge clk);
    ifc.rready = 1'b1;
    @(negedge clk); ifc.rready = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int awd, input int wd, input int hold,
                    output logic [1:0] r, output int lat);
    int ka, kw, n;
    fork
      begin
        int m;
        m = 0;
        repeat (awd) @(negedge clk);
        ifc.awaddr = a; ifc.awvalid = 1'b1;
        while (!ifc.awready && m < 100) begin @(negedge clk); m++; end
        chk("aw_wait", 32'(m < 100), 32'd1);
        ka = cyc + 1;
        @(negedge clk); ifc.awvalid = 1'b0;
      end
      begin
        int m;
        m = 0;
        repeat (wd) @(negedge clk);
        ifc.wdata = d; ifc.wstrb = s; ifc.wvalid = 1'b1;
        while (!ifc.wready && m < 100) begin @(negedge clk); m++; end
        chk("w_wait", 32'(m < 100), 32'd1);
        kw = cyc + 1;
        @(negedge clk); ifc.wvalid = 1'b0;
      end
    join
    n = 0;
    while (!ifc.bvalid && n < 100) begin @(negedge clk); n++; end
    chk("b_wait", 32'(n < 100), 32'd1);
    lat = cyc - ((ka > kw) ? ka : kw) + 1;
    r = ifc.bresp;
    repeat (hold) @(negedge clk);
    ifc.bready = 1'b1;
    @(negedge clk); ifc.bready = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_arready"}, 32'(ifc.arready), 32'd1);
    chk({tag, "_awready"}, 32'(ifc.awready), 32'd1);
    chk({tag, "_wready"},  32'(ifc.wready),  32'd1);
    chk({tag, "_rvalid"},  32'(ifc.rvalid),  32'd0);
    chk({tag, "_bvalid"},  32'(ifc.bvalid),  32'd0);
    chk({tag, "_rdata"},   ifc.rdata,        32'd0);
    chk({tag, "_rresp"},   32'(ifc.rresp),   32'd0);
    chk({tag, "_bresp"},   32'(ifc.bresp),   32'd0);
  endtask

  // Mostly the first eight words so that reads and writes collide.
  // Occasionally an out-of-range address just above the array or far above it.
  function automatic logic [AW-1:0] rnd_addr();
    int p;
    p = $urandom_range(0, 9);
    if (p == 0) return AW'(16'h0100 | 16'($urandom_range(0, 255)));
    if (p == 1) return AW'(16'h8000 | 16'($urandom));
    return AW'($urandom_range(0, 31));
  endfunction

  // Watchdog: stops the run if it never reaches the summary.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- main
  logic [31:0] d;
  logic [1:0]  r;
  int          lat;

  initial begin
    ifc.araddr = '0; ifc.arvalid = 1'b0; ifc.rready = 1'b0;
    ifc.awaddr = '0; ifc.awvalid = 1'b0;
    ifc.wdata  = '0; ifc.wstrb   = '0; ifc.wvalid = 1'b0; ifc.bready = 1'b0;

    repeat (2) @(negedge clk);
    chk_reset("rst0");
    #2 rst = 1'b0;
    @(negedge clk);

    // Give every word a known value.
    for (int i = 0; i < NW; i++) wr(AW'(i * 4), $urandom, 4'hF, 0, 0, 0, r, lat);

    // Same-cycle AW/W, then a readback.
    wr(16'h0010, 32'hDEADBEEF, 4'hF, 0, 0, 0, r, lat);
    chk("t1_bresp", 32'(r), 32'd0);
    chk("t1_wlat", 32'(lat), 32'(WRL));
    rd(16'h0010, 0, d, r, lat);
    chk("t1_rdata", d, 32'hDEADBEEF);
    chk("t1_rresp", 32'(r), 32'd0);
    chk("t1_rlat", 32'(lat), 32'(RDL));

    // W leads AW by 3 cycles, updating one byte only.
    wr(16'h0014, 32'h11223344, 4'hF, 0, 0, 0, r, lat);
    wr(16'h0014, 32'h0000AB00, 4'h2, 3, 0, 0, r, lat);
    chk("t2_bresp", 32'(r), 32'd0);
    rd(16'h0014, 0, d, r, lat);
    chk("t2_rdata", d, 32'h1122AB44);

    // rready held low for 5 cycles. The compare process checks stability every cycle.
    rd(16'h0014, 5, d, r, lat);
    chk("t3_rdata", d, 32'h1122AB44);

    // Out-of-range read and write, aliasing word 4.
    rd(16'h0110, 0, d, r, lat);
    chk("t4_rresp", 32'(r), 32'd2);
    chk("t4_rdata", d, 32'd0);
    wr(16'h0110, 32'h12345678, 4'hF, 0, 0, 0, r, lat);
    chk("t4_bresp", 32'(r), 32'd2);
    rd(16'h0010, 0, d, r, lat);
    chk("t4_keep", d, 32'hDEADBEEF);

    // A write with wstrb=0 changes nothing and still gets OKAY.
    wr(16'h0010, 32'h0BADF00D, 4'h0, 0, 0, 0, r, lat);
    chk("t5_bresp", 32'(r), 32'd0);
    rd(16'h0010, 0, d, r, lat);
    chk("t5_keep", d, 32'hDEADBEEF);

    // The read sample and the write commit land on the same edge.
    wr(16'h0020, 32'h1, 4'hF, 0, 0, 0, r, lat);
    fork
      rd(16'h0020, 0, d, r, lat);
      begin
        logic [1:0] r2;
        int         l2;
        repeat (RDL - WRL) @(negedge clk);
        wr(16'h0020, 32'h2, 4'hF, 0, 0, 0, r2, l2);
      end
    join
    chk("t6_old", d, 32'h1);
    rd(16'h0020, 0, d, r, lat);
    chk("t6_new", d, 32'h2);

    // Reset pulsed while both engines are mid-latency.
    wr(16'h0030, 32'hCAFE0030, 4'hF, 0, 0, 0, r, lat);
    ifc.araddr = 16'h0030; ifc.arvalid = 1'b1;
    ifc.awaddr = 16'h0030; ifc.awvalid = 1'b1;
    ifc.wdata  = 32'h99999999; ifc.wstrb = 4'hF; ifc.wvalid = 1'b1;
    @(negedge clk);
    ifc.arvalid = 1'b0; ifc.awvalid = 1'b0; ifc.wvalid = 1'b0;
    chk("t7_rbusy", 32'(ifc.arready), 32'd0);
    chk("t7_wbusy", 32'(ifc.awready), 32'd0);
    #2 rst = 1'b1;
    #1 chk_reset("t7");
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    rd(16'h0030, 0, d, r, lat);
    chk("t7_keep", d, 32'hCAFE0030);

    // Randomized concurrent traffic, checked by the model.
    fork
      begin
        logic [31:0] rd_d;
        logic [1:0]  rd_r;
        int          rd_l;
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          rd(rnd_addr(), $urandom_range(0, 3), rd_d, rd_r, rd_l);
        end
      end
      begin
        logic [1:0] wr_r;
        int         wr_l;
        for (int j = 0; j < 150; j++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          wr(rnd_addr(), $urandom, 4'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 2), wr_r, wr_l);
        end
      end
    join

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_lite_sram_resp.md
AXI_LITE_SRAM_RESP -- requirements
Module: axi_lite_sram_resp

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, 32, byte-address width.
REQ-002 SHALL have parameters: DEPTH_LOG2, 12, log2 of the number of 32-bit words.
REQ-003 SHALL have parameters: RD_LAT, 2, cycles from AR handshake to rvalid (range 1..15).
REQ-004 SHALL have parameters: WR_LAT, 1, cycles from the later of the AW/W handshakes to bvalid (range 1..15).
REQ-005 SHALL have the ports below, listed as name, direction, width, meaning:
- clk, in, 1, sole clock; all state on rising edge.
- rst, in, 1, one clock; reset is asynchronous and active-high.
- araddr, in, ADDR_WIDTH, read byte address; arvalid, in, 1; arready, out, 1.
- rdata, out, 32; rresp, out, 2; rvalid, out, 1; rready, in, 1.
- awaddr, in, ADDR_WIDTH; awvalid, in, 1; awready, out, 1.
- wdata, in, 32; wstrb, in, 4, byte enables; wvalid, in, 1; wready, out, 1.
- bresp, out, 2; bvalid, out, 1; bready, in, 1.

Function
REQ-006 SHALL treat a channel handshake as valid&ready high at a rising edge; ready SHALL never depend combinationally on the same channel's valid.
REQ-007 SHALL form the word index as addr[DEPTH_LOG2+1:2], ignore addr[1:0], and flag out-of-range when any addr bit above DEPTH_LOG2+1 is set.
REQ-008 SHALL have read FSM states R_IDLE, R_WAIT, R_RESP, with arready=1 only in R_IDLE.
REQ-009 SHALL, on AR handshake, latch the address, load the counter with RD_LAT-1 and enter R_WAIT (R_RESP directly if RD_LAT=1).
REQ-010 SHALL decrement the counter in R_WAIT; at zero it SHALL sample memory into rdata and enter R_RESP with rvalid=1.
REQ-011 SHALL hold rdata/rresp/rvalid stable in R_RESP until rready=1, then return to R_IDLE; back-to-back reads cost one idle cycle.
REQ-012 SHALL have write FSM states W_IDLE, W_WAIT, W_RESP; in W_IDLE awready and wready SHALL each be 1 until their own channel has been captured.
REQ-013 SHALL accept AW and W in either order or in the same cycle, and leave W_IDLE only when both are captured, loading the counter with WR_LAT-1.
REQ-014 SHALL commit the write at the cycle bvalid rises: byte i written iff wstrb[i]=1; wstrb=0 SHALL write nothing and still respond OKAY.
REQ-015 SHALL hold bvalid/bresp until bready=1, then return to W_IDLE with both capture flags cleared.
REQ-016 SHALL return rresp/bresp=2'b00 (OKAY) in range and 2'b10 (SLVERR) out of range; out-of-range reads return rdata=0 and out-of-range writes modify nothing.
REQ-017 SHALL operate the read and write FSMs independently; when the read sample and the write commit hit the same word in the same cycle, the read SHALL return the pre-write data.
REQ-018 SHALL ignore arvalid/awvalid/wvalid while the corresponding channel is not ready, with no side effects.

Reset
REQ-019 SHALL, on rst=1 asynchronously, force both FSMs to idle, clear counters and capture flags, and drive arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
REQ-020 SHALL NOT reset memory contents; reset mid-transaction SHALL abandon it, and a write not yet committed SHALL leave memory unchanged.
REQ-021 SHALL sample no handshakes in the first edge after rst deasserts unless rst is already low before that edge.

Verification
REQ-022 SHALL pass: AW=0x10 and W=0xDEADBEEF/wstrb=0xF in the same cycle, bready=1 -> bvalid after WR_LAT cycles with bresp=00; then read 0x10 -> rvalid RD_LAT cycles after AR with rdata=0xDEADBEEF.
REQ-023 SHALL pass: W before AW by 3 cycles, wstrb=0x2, wdata=0x0000AB00 over 0x11223344 -> readback 0x1122AB44.
REQ-024 SHALL pass: read with rready held low for 5 cycles -> rvalid and rdata stable throughout, arready=0 until rready.
REQ-025 SHALL pass: araddr with bit DEPTH_LOG2+2 set -> rresp=10 and rdata=0; the same address written -> bresp=10 and memory unchanged.
REQ-026 SHALL pass: same-cycle read sample and write commit to 0x20 (old 0x1, new 0x2) -> read returns 0x1 and a later read returns 0x2.
REQ-027 SHALL pass: rst pulsed while in R_WAIT and W_WAIT -> all outputs take reset values immediately and the target word is unchanged.
